truck_lane_mover: RTL and testbench

Downstream consumer of the truck slow-clock divider in Fury on Wheels. Turns the divided square wave into a one-cycle movement tick. Spawns a truck in a pseudo-random lane, steps it toward the player once per tick, and detects whether it collides with or passes the player. Feeds the display/renderer with the truck position and the game controller with crash, pass and score.

---
 rtl/fury_pkg.sv | 27 ++
 rtl/lane_lfsr.sv | 31 +++
 rtl/truck_lane_mover.sv | 161 ++++++++++++++++
 tb/tb_truck_lane_mover.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fury_pkg.sv
// Shared types and constants for the Fury on Wheels truck lane mover.
//   state_e      : truck FSM state encoding
//   LANE_*       : lane codes; NO_LANE is the "player not in any lane" value
//   LFSR_TAPS    : tap mask for the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1)
//   map_lane()   : folds an LFSR candidate onto a legal lane 0..2
package fury_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        MOVE  = 2'd2,
        CRASH = 2'd3
    } state_e;

    localparam logic [1:0] LANE_L  = 2'd0;
    localparam logic [1:0] LANE_C  = 2'd1;
    localparam logic [1:0] LANE_R  = 2'd2;
    localparam logic [1:0] NO_LANE = 2'd3;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Code 3 is not a drivable lane, so it folds onto the centre lane.
    function automatic logic [1:0] map_lane(input logic [1:0] cand);
        return (cand == NO_LANE) ? LANE_C : cand;
    endfunction

endpackage

// File: rtl/lane_lfsr.sv
// 8-bit Fibonacci LFSR that free-runs every clock and offers a lane
// candidate for the next truck spawn.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset (loads SEED)
//   lane_o  : mapped lane 0..2 derived from the low two LFSR bits
module lane_lfsr
    import fury_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [1:0] lane_o
);

    logic [7:0] lfsr_q, lfsr_d;

    // Tap mask includes bit 7, so the update is invertible and a nonzero
    // seed can never collapse to the all-zero lockup state.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) lfsr_q <= SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign lane_o = map_lane(lfsr_q[1:0]);

endmodule

// File: rtl/truck_lane_mover.sv
// Truck spawner/mover. Converts the divided slow clock into a one-cycle
// tick, spawns a truck in a pseudo-random lane, steps it toward the player
// once per tick and resolves crash / pass at position 0.
//   clock_in     : system clock
//   rst_n        : synchronous active-low reset
//   slow_clk     : divided square wave (already in clock_in domain)
//   enable       : game running
//   player_lane  : player lane 0..2, 3 = no lane (never collides)
//   truck_x      : truck position, ROAD_LEN-1 at spawn, 0 at the player
//   truck_lane   : truck lane 0..2
//   truck_active : truck visible (SPAWN/MOVE/CRASH)
//   crash        : high for the whole CRASH state
//   pass_pulse   : one cycle when a truck passes the player
//   score        : passed trucks, saturating at 255
module truck_lane_mover
    import fury_pkg::*;
#(
    parameter int         ROAD_LEN   = 16,
    parameter int         POS_W      = 4,
    parameter int         CRASH_HOLD = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic             clock_in,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             enable,
    input  logic [1:0]       player_lane,
    output logic [POS_W-1:0] truck_x,
    output logic [1:0]       truck_lane,
    output logic             truck_active,
    output logic             crash,
    output logic             pass_pulse,
    output logic [7:0]       score
);

    localparam int HOLD_W = (CRASH_HOLD > 1) ? $clog2(CRASH_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CRASH_HOLD - 1);
    localparam logic [POS_W-1:0]  X_SPAWN   = POS_W'(ROAD_LEN - 1);

    state_e            state_q, state_d;
    logic [POS_W-1:0]  x_q, x_d;
    logic [1:0]        lane_q, lane_d;
    logic              active_q, active_d;
    logic              crash_q, crash_d;
    logic              pass_q, pass_d;
    logic [7:0]        score_q, score_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              slow_q;
    logic              tick_q;
    logic [1:0]        lane_cand;

    lane_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (clock_in),
        .rst_ni (rst_n),
        .lane_o (lane_cand)
    );

    // Rising-edge detect on slow_clk, registered so the FSM sees a clean
    // single-cycle tick. slow_q resets high so a slow_clk already high at
    // reset release is not mistaken for an edge.
    always_ff @(posedge clock_in) begin
        if (!rst_n) begin
            slow_q <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            slow_q <= slow_clk;
            tick_q <= slow_clk & ~slow_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        lane_d   = lane_q;
        active_d = active_q;
        crash_d  = crash_q;
        pass_d   = 1'b0;
        score_d  = score_q;
        hold_d   = hold_q;
        unique case (state_q)
            IDLE: begin
                active_d = 1'b0;
                crash_d  = 1'b0;
                if (enable && tick_q) state_d = SPAWN;
            end
            SPAWN: begin
                if (!enable) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end else begin
                    x_d      = X_SPAWN;
                    lane_d   = lane_cand;
                    active_d = 1'b1;
                    state_d  = MOVE;
                end
            end
            MOVE: begin
                // An enable drop beats a coincident tick: no pass, no crash.
                if (!enable) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end else if (tick_q) begin
                    if (x_q != '0) begin
                        x_d = x_q - POS_W'(1);
                    end else if (lane_q == player_lane) begin
                        state_d = CRASH;
                        crash_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        pass_d  = 1'b1;
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        state_d = SPAWN;
                    end
                end
            end
            CRASH: begin
                // enable is deliberately ignored: the crash always plays out.
                if (tick_q) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d  = IDLE;
                        crash_d  = 1'b0;
                        active_d = 1'b0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            lane_q   <= LANE_L;
            active_q <= 1'b0;
            crash_q  <= 1'b0;
            pass_q   <= 1'b0;
            score_q  <= 8'd0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            lane_q   <= lane_d;
            active_q <= active_d;
            crash_q  <= crash_d;
            pass_q   <= pass_d;
            score_q  <= score_d;
            hold_q   <= hold_d;
        end
    end

    assign truck_x      = x_q;
    assign truck_lane   = lane_q;
    assign truck_active = active_q;
    assign crash        = crash_q;
    assign pass_pulse   = pass_q;
    assign score        = score_q;

endmodule

// File: tb/tb_truck_lane_mover.sv
// Self-checking bench for truck_lane_mover (ROAD_LEN=4). Expected per-tick
// outputs are queued when a slow_clk edge is driven and compared when the
// result becomes visible two clock_in cycles later.
module tb_truck_lane_mover;
    import fury_pkg::*;

    localparam int ROAD_LEN = 4;
    localparam int POS_W    = 4;
    localparam int HOLD     = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             slow_clk;
    logic             enable;
    logic [1:0]       player_lane;
    logic [POS_W-1:0] truck_x;
    logic [1:0]       truck_lane;
    logic             truck_active;
    logic             crash;
    logic             pass_pulse;
    logic [7:0]       score;

    truck_lane_mover #(
        .ROAD_LEN   (ROAD_LEN),
        .POS_W      (POS_W),
        .CRASH_HOLD (HOLD),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clock_in     (clk),
        .rst_n        (rst_n),
        .slow_clk     (slow_clk),
        .enable       (enable),
        .player_lane  (player_lane),
        .truck_x      (truck_x),
        .truck_lane   (truck_lane),
        .truck_active (truck_active),
        .crash        (crash),
        .pass_pulse   (pass_pulse),
        .score        (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int act;
        int crs;
        int pas;
        int scr;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One slow_clk period: rise, wait for the 2-cycle latency, compare,
    // then confirm pass_pulse lasted a single cycle.
    task automatic do_tick();
        exp_t e;
        slow_clk = 1'b1;
        cyc(2);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("x",      int'(truck_x),      e.x);
            chk("active", int'(truck_active), e.act);
            chk("crash",  int'(crash),        e.crs);
            chk("pass",   int'(pass_pulse),   e.pas);
            chk("score",  int'(score),        e.scr);
        end
        slow_clk = 1'b0;
        cyc(1);
        chk("pass_w", int'(pass_pulse), 0);
        cyc(1);
    endtask

    task automatic tick_exp(input int x, input int a, input int c, input int p, input int s);
        sb.push_back('{x: x, act: a, crs: c, pas: p, scr: s});
        do_tick();
    endtask

    task automatic pulse();
        slow_clk = 1'b1;
        cyc(2);
        slow_clk = 1'b0;
        cyc(2);
    endtask

    initial begin
        rst_n       = 1'b0;
        slow_clk    = 1'b1;
        enable      = 1'b1;
        player_lane = NO_LANE;
        cyc(2);
        chk("rst_lfsr", int'(dut.u_lfsr.lfsr_q), 8'hA5);
        rst_n = 1'b1;

        // slow_clk high across reset release must not produce a tick.
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("rst_state",  int'(dut.state_q), int'(IDLE));
            chk("rst_active", int'(truck_active), 0);
            chk("rst_x",      int'(truck_x), 0);
            chk("rst_score",  int'(score), 0);
        end
        chk("rst_crash", int'(crash), 0);
        chk("rst_pass",  int'(pass_pulse), 0);
        slow_clk = 1'b0;
        cyc(2);

        // Basic run: spawn then 3,2,1,0 and a pass on the 5th tick.
        tick_exp(0, 0, 0, 0, 0);
        chk("spawn_x",      int'(truck_x), 3);
        chk("spawn_active", int'(truck_active), 1);
        chk("lane_legal",   int'(truck_lane <= LANE_R), 1);
        tick_exp(2, 1, 0, 0, 0);
        tick_exp(1, 1, 0, 0, 0);
        tick_exp(0, 1, 0, 0, 0);
        tick_exp(0, 1, 0, 1, 1);
        chk("respawn_x", int'(truck_x), 3);

        // Crash: player steers into the truck's lane.
        player_lane = truck_lane;
        tick_exp(2, 1, 0, 0, 1);
        tick_exp(1, 1, 0, 0, 1);
        tick_exp(0, 1, 0, 0, 1);
        tick_exp(0, 1, 1, 0, 1);
        for (int i = 0; i < HOLD - 1; i++) tick_exp(0, 1, 1, 0, 1);
        tick_exp(0, 0, 0, 0, 1);

        // enable dropped while truck_x == 2.
        player_lane = NO_LANE;
        tick_exp(0, 0, 0, 0, 1);
        tick_exp(2, 1, 0, 0, 1);
        enable = 1'b0;
        cyc(1);
        chk("drop_active", int'(truck_active), 0);
        chk("drop_state",  int'(dut.state_q), int'(IDLE));
        chk("drop_pass",   int'(pass_pulse), 0);
        chk("drop_score",  int'(score), 1);
        cyc(1);

        // Tick and enable drop together at x==0: drop wins, no pass.
        enable = 1'b1;
        tick_exp(2, 0, 0, 0, 1);
        tick_exp(2, 1, 0, 0, 1);
        tick_exp(1, 1, 0, 0, 1);
        tick_exp(0, 1, 0, 0, 1);
        slow_clk = 1'b1;
        cyc(1);
        enable = 1'b0;
        cyc(1);
        chk("race_state",  int'(dut.state_q), int'(IDLE));
        chk("race_pass",   int'(pass_pulse), 0);
        chk("race_score",  int'(score), 1);
        chk("race_active", int'(truck_active), 0);
        slow_clk = 1'b0;
        cyc(2);

        // Saturation: 254 more passes bring score to 255, one more holds it.
        enable = 1'b1;
        pulse();
        for (int i = 0; i < 254 * 4; i++) pulse();
        chk("sat_score", int'(score), 255);
        tick_exp(2, 1, 0, 0, 255);
        tick_exp(1, 1, 0, 0, 255);
        tick_exp(0, 1, 0, 0, 255);
        tick_exp(0, 1, 0, 1, 255);

        // Reset during a crash.
        player_lane = truck_lane;
        tick_exp(2, 1, 0, 0, 255);
        tick_exp(1, 1, 0, 0, 255);
        tick_exp(0, 1, 0, 0, 255);
        tick_exp(0, 1, 1, 0, 255);
        tick_exp(0, 1, 1, 0, 255);
        rst_n = 1'b0;
        cyc(1);
        chk("mrst_crash",  int'(crash), 0);
        chk("mrst_score",  int'(score), 0);
        chk("mrst_active", int'(truck_active), 0);
        chk("mrst_lfsr",   int'(dut.u_lfsr.lfsr_q), 8'hA5);
        chk("mrst_state",  int'(dut.state_q), int'(IDLE));
        rst_n = 1'b1;
        cyc(1);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
